// File: rtl/fp_pipe_pkg.sv
// Shared FP pipeline definitions: forward-select codes, multi-cycle FSM states, latency width.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package fp_pipe_pkg;

   localparam int LAT_W = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic [1:0] {
      MC_IDLE = 2'b00,
      MC_BUSY = 2'b01,
      MC_DONE = 2'b10
   } mc_state_t;

   // A source operand collides with a destination only if it is really read as an FP register
   function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
      return used && (rs == rd);
   endfunction

endpackage

// File: rtl/fp_fwd_sel.sv
// Per-operand FP forwarding select: MEM beats WB beats register file; f0 forwards normally.
// Latency: combinational, same cycle.
// Backpressure: none; stalls are decided by the parent.
module fp_fwd_sel
   import fp_pipe_pkg::*;
(
   input  logic       used,
   input  logic [4:0] rs,
   input  logic [4:0] mem_rd,
   input  logic       mem_fp_wb,
   input  logic [4:0] wb_rd,
   input  logic       wb_fp_wb,
   output logic [1:0] sel
);

   // Youngest producer wins so a dependent op never sees stale WB data
   always_comb begin
      sel = FWD_REG;
      if (mem_fp_wb && src_hit(used, rs, mem_rd))
         sel = FWD_MEM;
      else if (wb_fp_wb && src_hit(used, rs, wb_rd))
         sel = FWD_WB;
   end

endmodule

// File: rtl/fp_hazard_ctrl.sv
// FP hazard/forwarding control: forward selects, ID stall, single-entry multi-cycle sequencer.
// Latency: selects and stall are same-cycle; mc_wr_en arrives id_mc_lat cycles after mc_start.
// Backpressure: stall_id holds IF/ID on load-use, pending RAW/WAW and a busy multi-cycle unit.
module fp_hazard_ctrl #(
   parameter int LAT_W = fp_pipe_pkg::LAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rs3,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_use_rs3,
   input  logic [4:0]       id_rd,
   input  logic             id_fp_wb,
   input  logic             id_mc,
   input  logic [LAT_W-1:0] id_mc_lat,
   input  logic [4:0]       ex_rd,
   input  logic             ex_fp_load,
   input  logic [4:0]       mem_rd,
   input  logic             mem_fp_wb,
   input  logic [4:0]       wb_rd,
   input  logic             wb_fp_wb,
   input  logic             flush,
   output logic [1:0]       fwd_sel_rs1,
   output logic [1:0]       fwd_sel_rs2,
   output logic [1:0]       fwd_sel_rs3,
   output logic             stall_id,
   output logic             mc_start,
   output logic             mc_wr_en,
   output logic [4:0]       mc_rd,
   output logic             mc_busy
);
   import fp_pipe_pkg::*;

   mc_state_t        state, state_nxt;
   logic             pend_v;
   logic [4:0]       pend_rd;
   logic [LAT_W-1:0] cnt;
   logic [LAT_W-1:0] eff_lat;
   logic             hz_load, hz_raw, hz_waw, hz_struct, hazard, issue;

   fp_fwd_sel u_fwd_rs1 (.used(id_use_rs1), .rs(id_rs1), .mem_rd(mem_rd), .mem_fp_wb(mem_fp_wb),
                         .wb_rd(wb_rd), .wb_fp_wb(wb_fp_wb), .sel(fwd_sel_rs1));
   fp_fwd_sel u_fwd_rs2 (.used(id_use_rs2), .rs(id_rs2), .mem_rd(mem_rd), .mem_fp_wb(mem_fp_wb),
                         .wb_rd(wb_rd), .wb_fp_wb(wb_fp_wb), .sel(fwd_sel_rs2));
   fp_fwd_sel u_fwd_rs3 (.used(id_use_rs3), .rs(id_rs3), .mem_rd(mem_rd), .mem_fp_wb(mem_fp_wb),
                         .wb_rd(wb_rd), .wb_fp_wb(wb_fp_wb), .sel(fwd_sel_rs3));

   // The pending destination is simply the latched multi-cycle destination
   assign pend_rd = mc_rd;

   // Latencies below 2 cannot be sequenced through BUSY, so they are clamped up
   assign eff_lat = (id_mc_lat < LAT_W'(2)) ? LAT_W'(2) : id_mc_lat;

   // Hazard sources and the ID stall; flush kills ID so it never stalls
   always_comb begin
      hz_load   = ex_fp_load && (src_hit(id_use_rs1, id_rs1, ex_rd) ||
                                 src_hit(id_use_rs2, id_rs2, ex_rd) ||
                                 src_hit(id_use_rs3, id_rs3, ex_rd));
      hz_raw    = pend_v && (src_hit(id_use_rs1, id_rs1, pend_rd) ||
                             src_hit(id_use_rs2, id_rs2, pend_rd) ||
                             src_hit(id_use_rs3, id_rs3, pend_rd));
      hz_waw    = pend_v && id_fp_wb && (id_rd == pend_rd);
      hz_struct = id_mc && (state != MC_IDLE);
      hazard    = id_valid && (hz_load || hz_raw || hz_waw || hz_struct);
      stall_id  = hazard && !flush;
      issue     = id_valid && id_mc && !hazard && !flush;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MC_IDLE;
      else        state <= state_nxt;
   end

   // FSM next state; flush overrides both issue and DONE
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = MC_IDLE;
      end else begin
         case (state)
            MC_IDLE: if (issue) state_nxt = MC_BUSY;
            MC_BUSY: if (cnt == LAT_W'(1)) state_nxt = MC_DONE;
            MC_DONE: state_nxt = MC_IDLE;
            default: state_nxt = MC_IDLE;
         endcase
      end
   end

   // FSM outputs; a flushed op never writes back
   always_comb begin
      mc_start = issue;
      mc_wr_en = (state == MC_DONE) && !flush;
      mc_busy  = (state != MC_IDLE);
   end

   // Scoreboard entry and latency counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v <= 1'b0;
         cnt    <= '0;
         mc_rd  <= '0;
      end else if (flush) begin
         pend_v <= 1'b0;
         cnt    <= '0;
         mc_rd  <= '0;
      end else if (issue) begin
         pend_v <= 1'b1;
         cnt    <= eff_lat - LAT_W'(1);
         mc_rd  <= id_rd;
      end else if (state == MC_BUSY) begin
         cnt    <= cnt - LAT_W'(1);
      end else if (state == MC_DONE) begin
         pend_v <= 1'b0;
      end
   end

endmodule
